// File: rtl/screen_cmd_engine.sv
// Bulk clear/fill/copy sequencer for screen_ram port A, arbitrating per cycle with scanout.
// Accesses are issued only in granted cycles; a denied cycle simply holds all state.
module screen_cmd_engine #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned SCREEN_SIZE = 38400
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        cmd,
   input  logic              cmd_req,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [15:0]       len,
   input  logic [7:0]        fill_val,
   input  logic              abort,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_wren,
   input  logic [7:0]        mem_rdata,
   output logic              active,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      StIdle,
      StFill,
      StCpRd,
      StCpCap,
      StCpWr,
      StFinish
   } state_e;

   localparam logic [ADDR_W:0] Limit    = (ADDR_W + 1)'(SCREEN_SIZE);
   localparam logic [15:0]     ClearCnt = 16'(SCREEN_SIZE);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        fill_q, fill_d;
   logic [7:0]        data_q, data_d;
   logic              err_q, err_d;

   logic              dst_ok, src_ok;
   logic              req, wr;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;

   assign dst_ok = {1'b0, dst_q} < Limit;
   assign src_ok = {1'b0, src_q} < Limit;

   always_comb begin
      state_d = state_q;
      dst_d   = dst_q;
      src_d   = src_q;
      cnt_d   = cnt_q;
      fill_d  = fill_q;
      data_d  = data_q;
      err_d   = err_q;
      req     = 1'b0;
      wr      = 1'b0;
      addr    = '0;
      wdata   = '0;

      unique case (state_q)
         StIdle: begin
            err_d = 1'b0;
            if (cmd_req) begin
               dst_d  = dst_addr;
               src_d  = src_addr;
               cnt_d  = len;
               fill_d = fill_val;
               case (cmd)
                  8'h01: begin
                     dst_d   = '0;
                     cnt_d   = ClearCnt;
                     state_d = StFill;
                  end
                  8'h02:   state_d = (len == 16'd0) ? StFinish : StFill;
                  8'h03:   state_d = (len == 16'd0) ? StFinish : StCpRd;
                  default: begin
                     state_d = StFinish;
                     err_d   = 1'b1;
                  end
               endcase
            end
         end

         StFill: begin
            // Out-of-range addresses are never presented as a request.
            req   = dst_ok;
            wr    = dst_ok;
            addr  = dst_q;
            wdata = fill_q;
            if (abort || !dst_ok) begin
               state_d = StFinish;
               err_d   = 1'b1;
            end else if (mem_gnt) begin
               dst_d = dst_q + ADDR_W'(1);
               cnt_d = cnt_q - 16'd1;
               if (cnt_q == 16'd1) state_d = StFinish;
            end
         end

         StCpRd: begin
            req  = src_ok;
            addr = src_q;
            if (abort || !src_ok) begin
               state_d = StFinish;
               err_d   = 1'b1;
            end else if (mem_gnt) begin
               state_d = StCpCap;
            end
         end

         StCpCap: begin
            data_d = mem_rdata;
            if (abort) begin
               state_d = StFinish;
               err_d   = 1'b1;
            end else begin
               state_d = StCpWr;
            end
         end

         StCpWr: begin
            req   = dst_ok;
            wr    = dst_ok;
            addr  = dst_q;
            wdata = data_q;
            if (abort || !dst_ok) begin
               state_d = StFinish;
               err_d   = 1'b1;
            end else if (mem_gnt) begin
               src_d   = src_q + ADDR_W'(1);
               dst_d   = dst_q + ADDR_W'(1);
               cnt_d   = cnt_q - 16'd1;
               state_d = (cnt_q == 16'd1) ? StFinish : StCpRd;
            end
         end

         StFinish: state_d = StIdle;

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         dst_q   <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
         fill_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // Reset gates the strobes directly so a reset cycle can never write.
   assign mem_req   = req & rst_n;
   assign mem_wren  = wr & mem_gnt & rst_n;
   assign mem_addr  = addr;
   assign mem_wdata = wdata;
   assign active    = (state_q != StIdle);
   assign done      = (state_q == StFinish);
   assign err       = (state_q == StFinish) & err_q;

endmodule

// File: tb/tb_screen_cmd_engine.sv
// Randomized bench for screen_cmd_engine: a byte-array model of each command predicts the
// ordered write stream and error flag; a behavioural RAM answers reads.
module tb_screen_cmd_engine;

   localparam int unsigned AW = 16;
   localparam int unsigned SS = 384;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    cmd = '0;
   logic          cmd_req = 1'b0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW-1:0] src_addr = '0;
   logic [15:0]   len = '0;
   logic [7:0]    fill_val = '0;
   logic          abort = 1'b0;
   logic          mem_req;
   logic          mem_gnt = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_wdata;
   logic          mem_wren;
   logic [7:0]    mem_rdata = '0;
   logic          active, done, err;

   logic [AW-1:0] scan_addr = '0;
   logic [7:0]    ram[65536];
   logic [7:0]    model_ram[65536];
   logic [23:0]   obs_q[$];
   logic [23:0]   exp_q[$];
   int            total = 0;
   int            bad = 0;
   int            req_seen = 0;

   always #5 clk = ~clk;

   screen_cmd_engine #(
      .ADDR_W      (AW),
      .SCREEN_SIZE (SS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .cmd_req   (cmd_req),
      .dst_addr  (dst_addr),
      .src_addr  (src_addr),
      .len       (len),
      .fill_val  (fill_val),
      .abort     (abort),
      .mem_req   (mem_req),
      .mem_gnt   (mem_gnt),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wren  (mem_wren),
      .mem_rdata (mem_rdata),
      .active    (active),
      .done      (done),
      .err       (err)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Port A of screen_ram behind the parent mux.
   always @(posedge clk) begin
      if (mem_req && mem_gnt && mem_wren) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[(mem_req && mem_gnt) ? mem_addr : scan_addr];
      scan_addr <= AW'($urandom_range(0, SS - 1));
   end

   always @(negedge clk) begin
      if (mem_req) req_seen++;
      if (mem_wren) begin
         obs_q.push_back({mem_addr, mem_wdata});
         check_val("wren_without_gnt", 32'(mem_gnt), 32'd1);
         check_val("wren_without_req", 32'(mem_req), 32'd1);
      end
      if (mem_req) check_val("req_addr_in_range", 32'(mem_addr < AW'(SS)), 32'd1);
   end

   task automatic run_cmd(input logic [7:0] op, input int dst, input int src, input int n,
                          input logic [7:0] val, input int gmode, input int abort_cyc,
                          input int lim, input int exp_cyc, input bit poke);
      bit         e;
      int         nw;
      int         base;
      int         num;
      int         done_k;
      logic [7:0] b;
      exp_q.delete();
      e  = 1'b0;
      nw = 0;
      if (op == 8'h01 || op == 8'h02) begin
         base = (op == 8'h01) ? 0 : dst;
         num  = (op == 8'h01) ? int'(SS) : n;
         for (int i = 0; i < num; i++) begin
            if (lim >= 0 && nw == lim) break;
            if (base + i >= int'(SS)) begin
               e = 1'b1;
               break;
            end
            model_ram[base + i] = val;
            exp_q.push_back({16'(base + i), val});
            nw++;
         end
      end else if (op == 8'h03) begin
         for (int i = 0; i < n; i++) begin
            if (lim >= 0 && nw == lim) break;
            if (src + i >= int'(SS) || dst + i >= int'(SS)) begin
               e = 1'b1;
               break;
            end
            b = model_ram[src + i];
            model_ram[dst + i] = b;
            exp_q.push_back({16'(dst + i), b});
            nw++;
         end
      end else begin
         e = 1'b1;
      end
      if (abort_cyc > 0) e = 1'b1;

      @(posedge clk);
      #1;
      cmd      = op;
      dst_addr = AW'(dst);
      src_addr = AW'(src);
      len      = 16'(n);
      fill_val = val;
      cmd_req  = 1'b1;
      mem_gnt  = 1'($urandom);
      @(posedge clk);
      #1;
      cmd_req  = 1'b0;
      cmd      = 8'($urandom);
      dst_addr = AW'($urandom);
      src_addr = AW'($urandom);
      len      = 16'($urandom);
      fill_val = 8'($urandom);
      obs_q.delete();
      req_seen = 0;
      done_k   = 0;
      for (int k = 1; k <= 3000; k++) begin
         abort   = (k == abort_cyc);
         cmd_req = poke && (k == 2);
         if (poke && k == 2) begin
            cmd      = 8'h02;
            dst_addr = '0;
            len      = 16'd5;
         end
         mem_gnt = (gmode == 0) ? 1'b1 : (gmode == 2) ? (k % 2 == 1) : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         check_val("active_during_cmd", 32'(active), 32'd1);
         if (done) begin
            done_k = k;
            break;
         end
         @(posedge clk);
         #1;
      end
      abort   = 1'b0;
      cmd_req = 1'b0;
      check_val("done_seen", 32'(done_k != 0), 32'd1);
      check_val("err_at_done", 32'(err), 32'(e));
      if (exp_cyc > 0) check_val("done_latency", 32'(done_k), 32'(exp_cyc));
      if (!(op inside {8'h01, 8'h02, 8'h03}) || (op != 8'h01 && n == 0))
         check_val("no_req_expected", 32'(req_seen), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("active_after", 32'(active), 32'd0);
      check_val("done_after", 32'(done), 32'd0);
      check_val("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
         check_val("write_addr_data", 32'(obs_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic [7:0] b;
      int         diffs;
      int         r;
      logic [7:0] op;
      for (int i = 0; i < 65536; i++) begin
         b            = 8'($urandom);
         ram[i]       = b;
         model_ram[i] = b;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_active", 32'(active), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_req", 32'(mem_req), 32'd0);
      check_val("rst_wren", 32'(mem_wren), 32'd0);
      check_val("rst_addr", 32'(mem_addr), 32'd0);
      check_val("rst_wdata", 32'(mem_wdata), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_cmd(8'h02, 'h100, 0, 4, 8'hAA, 0, 0, -1, 5, 1'b0);
      run_cmd(8'h02, 'h140, 0, 3, 8'h5A, 2, 0, -1, 6, 1'b0);
      ram['h10] = 8'h12; model_ram['h10] = 8'h12;
      ram['h11] = 8'h34; model_ram['h11] = 8'h34;
      run_cmd(8'h03, 'h20, 'h10, 2, 8'h00, 0, 0, -1, 7, 1'b1);
      ram['h10] = 8'h55; model_ram['h10] = 8'h55;
      run_cmd(8'h03, 'h11, 'h10, 3, 8'h00, 0, 0, -1, 10, 1'b0);
      run_cmd(8'h07, 0, 0, 4, 8'h00, 0, 0, -1, 1, 1'b0);
      run_cmd(8'h01, 0, 0, 0, 8'h00, 0, 0, -1, SS + 1, 1'b0);
      run_cmd(8'h02, SS - 2, 0, 5, 8'hC3, 0, 0, -1, 4, 1'b0);
      run_cmd(8'h03, 'h80, 'h30, 4, 8'h00, 0, 4, 1, 5, 1'b0);

      // Reset lands on the 10th byte of a CLEAR.
      @(posedge clk);
      #1;
      cmd      = 8'h01;
      fill_val = 8'h77;
      cmd_req  = 1'b1;
      mem_gnt  = 1'b1;
      @(posedge clk);
      #1;
      cmd_req = 1'b0;
      obs_q.delete();
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_val("rst_cycle_wren", 32'(mem_wren), 32'd0);
      check_val("rst_cycle_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("rst_mid_active", 32'(active), 32'd0);
      check_val("rst_mid_done", 32'(done), 32'd0);
      check_val("rst_mid_err", 32'(err), 32'd0);
      check_val("rst_mid_addr", 32'(mem_addr), 32'd0);
      check_val("rst_mid_wdata", 32'(mem_wdata), 32'd0);
      check_val("rst_mid_wrcount", 32'(obs_q.size()), 32'd9);
      for (int i = 0; i < obs_q.size() && i < 9; i++)
         check_val("rst_mid_write", 32'(obs_q[i]), {8'h0, 16'(i), 8'h77});
      for (int i = 0; i < 9; i++) model_ram[i] = 8'h77;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_cmd(8'h02, 'h50, 0, 6, 8'h3C, 0, 0, -1, 7, 1'b0);

      for (int it = 0; it < 40; it++) begin
         int d;
         int s;
         int n;
         r  = int'($urandom_range(0, 19));
         op = (r == 0) ? 8'h01 : (r < 9) ? 8'h02 : (r < 17) ? 8'h03
                                         : 8'($urandom_range(4, 255));
         d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(SS - 12, SS + 4))
                                          : int'($urandom_range(0, SS - 1));
         s  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(SS - 12, SS + 4))
                                          : int'($urandom_range(0, SS - 1));
         n  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
         run_cmd(op, d, s, n, 8'($urandom), int'($urandom_range(0, 2)), 0, -1, 0, 1'b0);
      end

      @(posedge clk);
      #1;
      diffs = 0;
      for (int i = 0; i < int'(SS) + 32; i++)
         if (ram[i] !== model_ram[i]) diffs++;
      check_val("ram_contents", 32'(diffs), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
